prtc_host: RTL



---
 rtl/prtc_pkg.sv | 59 +++++
 rtl/prtc_host.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/prtc_pkg.sv
// Shared encodings for the IIgs RTC/BRAM host: op codes, C034 control bits, command-byte
// builders and the host FSM state type.
package prtc_pkg;

    localparam logic [1:0] OP_BRAM_WR = 2'b00;
    localparam logic [1:0] OP_BRAM_RD = 2'b01;
    localparam logic [1:0] OP_CLK_WR  = 2'b10;
    localparam logic [1:0] OP_CLK_RD  = 2'b11;

    localparam int unsigned CTL_START_BIT = 7;
    localparam int unsigned CTL_RD_BIT    = 6;

    typedef enum logic [3:0] {
        StIdle,
        StWait,
        StCmd1,
        StStb1,
        StCmd2,
        StStb2,
        StData,
        StStb3,
        StRdw,
        StDone
    } prtc_state_e;

    // Every C034 write of a transaction must carry the same rd bit.
    function automatic logic [7:0] ctl_byte(input logic rd);
        logic [7:0] b;
        b = '0;
        b[CTL_START_BIT] = 1'b1;
        b[CTL_RD_BIT]    = rd;
        return b;
    endfunction

    function automatic logic [7:0] clk_cmd(input logic rd, input logic [1:0] idx);
        return {rd, 3'b000, idx, 2'b01};
    endfunction

    function automatic logic short_addr(input logic [7:0] a);
        return a < 8'h14;
    endfunction

    // Only meaningful for short_addr() addresses: 0x00-0x0F or 0x10-0x13.
    function automatic logic [7:0] short_cmd(input logic rd, input logic [4:0] a);
        if (!a[4]) begin
            return {rd, 1'b1, a[3:0], 2'b01};
        end
        return {rd, 3'b010, a[1:0], 2'b01};
    endfunction

    function automatic logic [7:0] ext_cmd1(input logic rd, input logic [2:0] a_hi);
        return {rd, 4'b0111, a_hi};
    endfunction

    function automatic logic [7:0] ext_cmd2(input logic [4:0] a_lo);
        return {1'b0, a_lo, 2'b00};
    endfunction

endpackage

// File: rtl/prtc_host.sv
// prtc_host: turns one BRAM/clock byte request into the C033/C034 write/strobe/read sequence.
// Define PRTC_SHORT_CMD_EN to use single-byte commands for BRAM addresses 0x00-0x13.
module prtc_host
    import prtc_pkg::*;
#(
    parameter int unsigned RD_SETTLE = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cen,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       bus_addr,
    output logic [7:0] bus_dout,
    input  logic [7:0] bus_din,
    output logic       bus_rw,
    output logic       bus_strobe
);

    localparam int unsigned SettleW = (RD_SETTLE > 1) ? $clog2(RD_SETTLE) : 1;
    localparam logic [SettleW-1:0] SettleLast = SettleW'(RD_SETTLE - 1);

    prtc_state_e        state_q, state_d;
    logic [1:0]         op_q;
    logic [7:0]         addr_q;
    logic [7:0]         wdata_q;
    logic [SettleW-1:0] settle_q;

    logic       is_rd, is_wr, is_clk, short_ok, use_ext, settle_done, accept;
    logic [7:0] byte1, byte2, ctl;
    logic       step_addr, step_rw, step_strobe;
    logic [7:0] step_dout;

    assign is_rd       = op_q[0];
    assign is_wr       = ~op_q[0];
    assign is_clk      = op_q[1];
    assign accept      = cmd_valid && (state_q == StIdle);
    assign settle_done = (settle_q == SettleLast);

`ifdef PRTC_SHORT_CMD_EN
    assign short_ok = short_addr(addr_q);
`else
    assign short_ok = 1'b0;
`endif

    assign use_ext = ~is_clk && ~short_ok;
    assign ctl     = ctl_byte(is_rd);
    assign byte2   = ext_cmd2(addr_q[4:0]);

    always_comb begin
        if (is_clk) begin
            byte1 = clk_cmd(is_rd, addr_q[1:0]);
        end else if (short_ok) begin
            byte1 = short_cmd(is_rd, addr_q[4:0]);
        end else begin
            byte1 = ext_cmd1(is_rd, addr_q[7:5]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (cmd_valid) state_d = StWait;
            StWait: if (cen) state_d = StCmd1;
            StCmd1: if (cen) state_d = StStb1;
            StStb1: begin
                if (cen) begin
                    if (use_ext)    state_d = StCmd2;
                    else if (is_wr) state_d = StData;
                    else            state_d = StStb3;
                end
            end
            StCmd2: if (cen) state_d = StStb2;
            StStb2: if (cen) state_d = is_wr ? StData : StStb3;
            StData: if (cen) state_d = StStb3;
            StStb3: if (cen) state_d = is_wr ? StDone : StRdw;
            StRdw:  if (cen && settle_done) state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Bus values for the step being entered; they are registered on the cen edge.
    always_comb begin
        step_addr   = 1'b0;
        step_dout   = 8'h00;
        step_rw     = 1'b1;
        step_strobe = 1'b0;
        case (state_d)
            StCmd1: begin
                step_dout = byte1;
                step_rw   = 1'b0;
            end
            StCmd2: begin
                step_dout = byte2;
                step_rw   = 1'b0;
            end
            StData: begin
                step_dout = wdata_q;
                step_rw   = 1'b0;
            end
            StStb1, StStb2, StStb3: begin
                step_addr   = 1'b1;
                step_dout   = ctl;
                step_rw     = 1'b0;
                step_strobe = 1'b1;
            end
            default: ;
        endcase
        cmd_ready = (state_q == StIdle);
        busy      = (state_q != StIdle);
        rsp_valid = (state_q == StDone);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q       <= 2'b00;
            addr_q     <= 8'h00;
            wdata_q    <= 8'h00;
            settle_q   <= '0;
            rsp_data   <= 8'h00;
            bus_addr   <= 1'b0;
            bus_dout   <= 8'h00;
            bus_rw     <= 1'b1;
            bus_strobe <= 1'b0;
        end else begin
            if (accept) begin
                op_q    <= cmd_op;
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
            end
            if (cen) begin
                bus_addr   <= step_addr;
                bus_dout   <= step_dout;
                bus_rw     <= step_rw;
                bus_strobe <= step_strobe;
                settle_q   <= (state_q == StRdw) ? settle_q + SettleW'(1) : '0;
                if ((state_q == StRdw) && settle_done) begin
                    rsp_data <= bus_din;
                end
            end
        end
    end

endmodule
